// File: rtl/hunter_mem_pkg.sv
// hunter_mem_pkg: shared memory-interface definitions.
//   MEM_OP_* : mem_op encodings, also used by the memory control logic.
//   ADDR_W   : byte address width.
//   DATA_W   : word width.
//   Also holds the arbiter's access-register struct, source and state enums,
//   and a helper that sizes the fetch starvation counter.
package hunter_mem_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] MEM_OP_READ = 2'b00;
  localparam logic [1:0] MEM_OP_SB   = 2'b01;
  localparam logic [1:0] MEM_OP_SH   = 2'b10;
  localparam logic [1:0] MEM_OP_SW   = 2'b11;

  typedef enum logic {
    SrcFetch,
    SrcData
  } src_e;

  typedef enum logic {
    StIdle,
    StAccess
  } state_e;

  typedef struct packed {
    logic              valid;
    src_e              src;
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } access_t;

  function automatic logic is_store(input logic [1:0] op);
    return op != MEM_OP_READ;
  endfunction

  // The counter must be able to hold FETCH_STARVE_MAX, and is never narrower than 2 bits.
  function automatic int unsigned starve_cnt_width(input int unsigned max_cnt);
    return (max_cnt < 4) ? 2 : $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: fetch/data priority with bounded fetch starvation.
//   clk, rst      : clock, synchronous active-low reset.
//   f_req, d_req  : fetch / data requests.
//   f_gnt, d_gnt  : combinational one-hot grants, forced low while rst is low.
// Data wins contention until a waiting fetch has lost FETCH_STARVE_MAX
// consecutive cycles; the fetch then takes the next cycle.
module mem_arb_prio
  import hunter_mem_pkg::*;
#(
  parameter int unsigned FETCH_STARVE_MAX = 3,
  localparam int unsigned CntW = starve_cnt_width(FETCH_STARVE_MAX)
) (
  input  logic clk,
  input  logic rst,
  input  logic f_req,
  input  logic d_req,
  output logic f_gnt,
  output logic d_gnt
);

  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
  logic            starve_hit;

  always_comb begin
    starve_hit = (starve_cnt_q == CntW'(FETCH_STARVE_MAX));
    f_gnt      = 1'b0;
    d_gnt      = 1'b0;
    if (rst) begin
      if (d_req && !(f_req && starve_hit)) begin
        d_gnt = 1'b1;
      end else if (f_req) begin
        f_gnt = 1'b1;
      end
    end

    starve_cnt_d = starve_cnt_q;
    if (!f_req || f_gnt) begin
      starve_cnt_d = '0;
    end else if (!starve_hit) begin
      starve_cnt_d = starve_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one combinational-read memory port between an
// instruction fetch port and a data load/store port.
//   clk, rst                         : clock, synchronous active-low reset.
//   f_req/f_addr -> f_gnt            : fetch request and grant.
//   f_rvalid/f_rdata                 : fetch response, two cycles after grant.
//   d_req/d_op/d_addr/d_wdata -> d_gnt : data request and grant.
//   d_rvalid/d_rdata                 : data response (stores return 0).
//   mem_op/mem_addr/mem_wdata        : memory command, valid during the access cycle.
//   mem_rdata                        : memory read data (combinational from mem_addr).
// Pipeline: grant (N) -> access register drives memory (N+1) -> response (N+2).
// A new grant may be taken every cycle.
module mem_arbiter
  import hunter_mem_pkg::*;
#(
  parameter int unsigned FETCH_STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic [1:0]        d_op,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [1:0]        mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  access_t           acc_q, acc_d;
  state_e            state;
  logic              f_rvalid_q, f_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  mem_arb_prio #(
    .FETCH_STARVE_MAX(FETCH_STARVE_MAX)
  ) u_prio (
    .clk  (clk),
    .rst  (rst),
    .f_req(f_req),
    .d_req(d_req),
    .f_gnt(f_gnt),
    .d_gnt(d_gnt)
  );

  // The access register alone carries the state: ACCESS exactly while it holds a request.
  assign state = acc_q.valid ? StAccess : StIdle;

  // Next access: whatever was granted this cycle, otherwise nothing.
  always_comb begin
    acc_d = '0;
    if (f_gnt) begin
      acc_d.valid = 1'b1;
      acc_d.src   = SrcFetch;
      acc_d.op    = MEM_OP_READ;
      acc_d.addr  = f_addr;
    end else if (d_gnt) begin
      acc_d.valid = 1'b1;
      acc_d.src   = SrcData;
      acc_d.op    = d_op;
      acc_d.addr  = d_addr;
      acc_d.wdata = d_wdata;
    end
  end

  // Memory command. Gating with rst keeps a latched store off the bus in the
  // cycle reset is asserted, before the register itself is cleared.
  always_comb begin
    mem_op    = MEM_OP_READ;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == StAccess && rst) begin
      mem_op    = acc_q.op;
      mem_addr  = acc_q.addr;
      mem_wdata = acc_q.wdata;
    end
  end

  // Response capture at the edge that ends the access cycle.
  always_comb begin
    f_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    f_rdata_d  = f_rdata_q;
    d_rdata_d  = d_rdata_q;
    if (state == StAccess) begin
      unique case (acc_q.src)
        SrcFetch: begin
          f_rvalid_d = 1'b1;
          f_rdata_d  = mem_rdata;
        end
        SrcData: begin
          d_rvalid_d = 1'b1;
          d_rdata_d  = is_store(acc_q.op) ? '0 : mem_rdata;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q      <= '0;
      f_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      acc_q      <= acc_d;
      f_rvalid_q <= f_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      f_rdata_q  <= f_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign f_rvalid = f_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign f_rdata  = f_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a byte-addressed
// little-endian memory model (combinational read, write at the clock edge).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req;
  logic [9:0]  f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        d_req;
  logic [1:0]  d_op;
  logic [9:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [1:0]  mem_op;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  // Memory model; preloads go through the same write process.
  logic [7:0]  mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .FETCH_STARVE_MAX(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_gnt    (f_gnt),
    .f_rvalid (f_rvalid),
    .f_rdata  (f_rdata),
    .d_req    (d_req),
    .d_op     (d_op),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .mem_op   (mem_op),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = {mem[mem_addr + 10'd3], mem[mem_addr + 10'd2],
                      mem[mem_addr + 10'd1], mem[mem_addr]};

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr]         <= pl_data[7:0];
      mem[pl_addr + 10'd1] <= pl_data[15:8];
      mem[pl_addr + 10'd2] <= pl_data[23:16];
      mem[pl_addr + 10'd3] <= pl_data[31:24];
    end else begin
      case (mem_op)
        2'b01: mem[mem_addr] <= mem_wdata[7:0];
        2'b10: begin
          mem[mem_addr]         <= mem_wdata[7:0];
          mem[mem_addr + 10'd1] <= mem_wdata[15:8];
        end
        2'b11: begin
          mem[mem_addr]         <= mem_wdata[7:0];
          mem[mem_addr + 10'd1] <= mem_wdata[15:8];
          mem[mem_addr + 10'd2] <= mem_wdata[23:16];
          mem[mem_addr + 10'd3] <= mem_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] w);
    pl_addr = a;
    pl_data = w;
    pl_en   = 1'b1;
    next_cycle();
    pl_en   = 1'b0;
  endtask

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    return {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
  endfunction

  initial begin
    rst     = 1'b0;
    f_req   = 1'b1;
    f_addr  = 10'h004;
    d_req   = 1'b1;
    d_op    = 2'b11;
    d_addr  = 10'h008;
    d_wdata = 32'h12345678;

    // Reset: no grants and no write even with both requesting.
    next_cycle();
    next_cycle();
    #1;
    check("rst_f_gnt", 32'(f_gnt), 32'd0);
    check("rst_d_gnt", 32'(d_gnt), 32'd0);
    check("rst_mem_op", 32'(mem_op), 32'd0);
    check("rst_f_rvalid", 32'(f_rvalid), 32'd0);
    check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    check("rst_f_rdata", f_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_starve", 32'(dut.u_prio.starve_cnt_q), 32'd0);
    f_req = 1'b0;
    d_req = 1'b0;
    rst   = 1'b1;
    next_cycle();

    // Store word then load the same address back-to-back.
    d_req = 1'b1; d_op = 2'b11; d_addr = 10'h010; d_wdata = 32'hDEADBEEF;
    #1;
    check("sw_d_gnt", 32'(d_gnt), 32'd1);
    check("sw_f_gnt", 32'(f_gnt), 32'd0);
    next_cycle();
    d_op = 2'b00; d_wdata = 32'h0;
    #1;
    check("ld_d_gnt", 32'(d_gnt), 32'd1);
    check("sw_mem_op", 32'(mem_op), 32'd3);
    check("sw_mem_addr", 32'(mem_addr), 32'h010);
    check("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
    next_cycle();
    d_req = 1'b0;
    #1;
    check("ld_mem_op", 32'(mem_op), 32'd0);
    check("ld_mem_addr", 32'(mem_addr), 32'h010);
    check("sw_d_rvalid", 32'(d_rvalid), 32'd1);
    check("sw_d_rdata", d_rdata, 32'd0);
    next_cycle();
    check("ld_d_rvalid", 32'(d_rvalid), 32'd1);
    check("ld_d_rdata", d_rdata, 32'hDEADBEEF);
    check("idle_mem_addr", 32'(mem_addr), 32'd0);
    next_cycle();
    check("ld_rvalid_once", 32'(d_rvalid), 32'd0);
    check("ld_rdata_hold", d_rdata, 32'hDEADBEEF);

    // Unaligned fetch spanning two words.
    preload(10'h010, 32'h03020100);
    preload(10'h014, 32'h07060504);
    f_req = 1'b1; f_addr = 10'h011;
    #1;
    check("uf_f_gnt", 32'(f_gnt), 32'd1);
    next_cycle();
    f_req = 1'b0;
    #1;
    check("uf_mem_addr", 32'(mem_addr), 32'h011);
    check("uf_mem_op", 32'(mem_op), 32'd0);
    check("uf_f_rvalid_early", 32'(f_rvalid), 32'd0);
    next_cycle();
    check("uf_f_rvalid", 32'(f_rvalid), 32'd1);
    check("uf_f_rdata", f_rdata, 32'h04030201);
    next_cycle();
    check("uf_rvalid_once", 32'(f_rvalid), 32'd0);

    // Store byte followed by a fetch of the word containing it.
    d_req = 1'b1; d_op = 2'b01; d_addr = 10'h012; d_wdata = 32'h000000AA;
    #1;
    check("sb_d_gnt", 32'(d_gnt), 32'd1);
    next_cycle();
    d_req = 1'b0; f_req = 1'b1; f_addr = 10'h010;
    #1;
    check("sb_f_gnt", 32'(f_gnt), 32'd1);
    check("sb_mem_op", 32'(mem_op), 32'd1);
    next_cycle();
    f_req = 1'b0;
    #1;
    check("sb_fetch_addr", 32'(mem_addr), 32'h010);
    check("sb_d_rvalid", 32'(d_rvalid), 32'd1);
    next_cycle();
    check("sb_f_rvalid", 32'(f_rvalid), 32'd1);
    check("sb_f_rdata", f_rdata, 32'h03AA0100);
    check("sb_no_d_rvalid", 32'(d_rvalid), 32'd0);
    next_cycle();

    // Store half at an odd address, loaded back as a word.
    preload(10'h040, 32'h00000000);
    d_req = 1'b1; d_op = 2'b10; d_addr = 10'h041; d_wdata = 32'h1234BEEF;
    next_cycle();
    d_op = 2'b00; d_addr = 10'h040; d_wdata = 32'h0;
    #1;
    check("sh_mem_op", 32'(mem_op), 32'd2);
    next_cycle();
    d_req = 1'b0;
    next_cycle();
    check("sh_ld_rdata", d_rdata, 32'h00BEEF00);
    next_cycle();

    // Continuous contention: D,D,D,F repeating.
    f_req = 1'b1; f_addr = 10'h100;
    d_req = 1'b1; d_op = 2'b00; d_addr = 10'h200;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("arb_gnt_%0d", i), {30'd0, f_gnt, d_gnt},
            (i % 4 == 3) ? 32'd2 : 32'd1);
      check($sformatf("arb_starve_%0d", i), 32'(dut.u_prio.starve_cnt_q), 32'(i % 4));
      check($sformatf("arb_rv_excl_%0d", i), 32'(f_rvalid & d_rvalid), 32'd0);
      next_cycle();
    end
    f_req = 1'b0;
    d_req = 1'b0;
    next_cycle();
    next_cycle();

    // Quiet bus.
    for (int i = 0; i < 5; i++) begin
      check($sformatf("quiet_gnt_%0d", i), {30'd0, f_gnt, d_gnt}, 32'd0);
      check($sformatf("quiet_mem_op_%0d", i), 32'(mem_op), 32'd0);
      check($sformatf("quiet_mem_addr_%0d", i), 32'(mem_addr), 32'd0);
      check($sformatf("quiet_starve_%0d", i), 32'(dut.u_prio.starve_cnt_q), 32'd0);
      next_cycle();
    end

    // Reset while a granted store is in flight.
    preload(10'h030, 32'h11223344);
    d_req = 1'b1; d_op = 2'b11; d_addr = 10'h030; d_wdata = 32'hCAFEF00D;
    #1;
    check("rs_d_gnt", 32'(d_gnt), 32'd1);
    next_cycle();
    d_req = 1'b0;
    rst   = 1'b0;
    #1;
    check("rs_mem_op_n1", 32'(mem_op), 32'd0);
    next_cycle();
    check("rs_mem_op_n2", 32'(mem_op), 32'd0);
    check("rs_d_rvalid_n2", 32'(d_rvalid), 32'd0);
    rst = 1'b1;
    next_cycle();
    check("rs_mem_op_n3", 32'(mem_op), 32'd0);
    check("rs_d_rvalid_n3", 32'(d_rvalid), 32'd0);
    next_cycle();
    check("rs_d_rvalid_n4", 32'(d_rvalid), 32'd0);
    check("rs_mem_word", mem_word(10'h030), 32'h11223344);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter FETCH_STARVE_MAX, default 3: consecutive cycles a waiting fetch may lose to data before it wins.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 f_req  input  1  fetch request; held with f_addr stable until f_gnt.
REQ-005 f_addr  input  10  fetch byte address.
REQ-006 f_gnt  output  1  fetch request accepted this cycle.
REQ-007 f_rvalid  output  1  f_rdata valid this cycle.
REQ-008 f_rdata  output  32  fetched word.
REQ-009 d_req  input  1  data request; held with d_op/d_addr/d_wdata stable until d_gnt.
REQ-010 d_op  input  2  memory operation, package encoding.
REQ-011 d_addr  input  10  data byte address, unaligned allowed.
REQ-012 d_wdata  input  32  store data.
REQ-013 d_gnt  output  1  data request accepted this cycle.
REQ-014 d_rvalid  output  1  d_rdata valid (loads and stores).
REQ-015 d_rdata  output  32  load data; 0 for stores.
REQ-016 mem_op  output  2  to memory mem_op.
REQ-017 mem_addr  output  10  to memory addr.
REQ-018 mem_wdata  output  32  to memory dataIn.
REQ-019 mem_rdata  input  32  from memory dataOut (combinational read).

Function
REQ-020 mem_op encoding SHALL be: 00 read/no-write, 01 store byte, 10 store half, 11 store word; fetches SHALL always issue 00.
REQ-021 At most one of f_gnt/d_gnt SHALL be high per cycle; gnt SHALL be combinational from req and arbitration state, never high while rst low.
REQ-022 Only d_req high -> d_gnt; only f_req high -> f_gnt; neither -> no grant.
REQ-023 Both high: d_gnt unless starve_cnt == FETCH_STARVE_MAX, then f_gnt.
REQ-024 starve_cnt (2 bits min, saturating at FETCH_STARVE_MAX) SHALL increment when f_req high and f_gnt low, clear on f_gnt or f_req low.
REQ-025 Granted request SHALL be latched at the grant edge into an access register (valid, source, op, addr, wdata); state ACCESS while valid, IDLE otherwise.
REQ-026 In ACCESS, mem_op/mem_addr/mem_wdata SHALL drive latched values; in IDLE, mem_op=00, mem_addr=0, mem_wdata=0.
REQ-027 At the end of ACCESS, mem_rdata SHALL be captured into the granted source's rdata register and its rvalid set for exactly one cycle; store responses SHALL return rdata=0.
REQ-028 Latency: grant in cycle N -> memory access in N+1 -> rvalid/rdata in N+2; throughput one access per cycle (new grant allowed in ACCESS).
REQ-029 Store in cycle N+1 followed by load of same address granted in N+1 SHALL return the stored data (memory commits at the edge ending N+1).
REQ-030 f_rvalid and d_rvalid SHALL never both be high in the same cycle.
REQ-031 rdata registers SHALL hold last value when rvalid low.

Reset
REQ-032 rst low at an edge SHALL clear access valid, starve_cnt, f_rvalid, d_rvalid, f_rdata, d_rdata to 0; state IDLE.
REQ-033 An access in flight when rst asserts SHALL be dropped: no rvalid after reset; a latched store SHALL not be issued in any cycle after reset.
REQ-034 During reset, mem_op SHALL be 00 so no write reaches memory.

Structure
REQ-035 Package hunter_mem_pkg SHALL hold MEM_OP_READ/SB/SH/SW constants, ADDR_W=10, DATA_W=32, shared with the memory control logic.
REQ-036 Priority and starve counter SHALL be one sub-module, mem_arb_prio (inputs f_req, d_req; outputs f_gnt, d_gnt); access/response pipeline stays in mem_arbiter.

Verification
REQ-037 d_req only, op=11, addr=0x010, wdata=0xDEADBEEF, then load op=00 addr=0x010 -> d_rvalid twice, second d_rdata=0xDEADBEEF, mem_op 11 then 00.
REQ-038 Both requesting continuously, FETCH_STARVE_MAX=3 -> grant pattern D,D,D,F repeating; no fetch wait exceeds 3 cycles.
REQ-039 Fetch addr=0x011 with memory preloaded 0x03020100 at 0x010 and 0x07060504 at 0x014 -> f_rdata=0x04030201 two cycles after f_gnt.
REQ-040 Store byte op=01 addr=0x012 wdata=0x000000AA granted cycle N, fetch 0x010 granted N+1 -> f_rdata byte2=0xAA in N+3.
REQ-041 Grant store at N, rst low at N+1 edge -> mem_op=00 from N+1 onward, no d_rvalid, memory word unchanged.
REQ-042 Both req low for 5 cycles -> no grants, mem_op=00, mem_addr=0, starve_cnt=0.
